// File: rtl/hazard_controller.sv
// Pipeline hazard sequencer: decides when IF/ID/EX must stall, bubble or flush
// for load-use, multi-cycle mult/div and taken-branch hazards, and counts
// stall cycles in a saturating counter.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   RUN      | normal issue; outputs are decoded combinationally from inputs
//   MD_BUSY  | mult/div occupies EX; hold the front end and insert bubbles
//   FLUSH    | extra flush cycles after a taken branch (FLUSH_CYCLES > 1)
module hazard_controller #(
  parameter int MD_LATENCY   = 8,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_WIDTH    = 16,
  parameter int AWIDTH       = 5
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 hz_i_ds_valid,
  input  logic [AWIDTH-1:0]    hz_i_ds_addr_rs1,
  input  logic [AWIDTH-1:0]    hz_i_ds_addr_rs2,
  input  logic                 hz_i_ds_use_rs2,
  input  logic                 hz_i_ds_md,
  input  logic                 hz_i_es_memread,
  input  logic                 hz_i_es_regwrite,
  input  logic [AWIDTH-1:0]    hz_i_es_addr_rd,
  input  logic                 hz_i_es_branch_taken,
  input  logic                 hz_i_cnt_clr,
  output logic                 hz_o_stall,
  output logic                 hz_o_bubble,
  output logic                 hz_o_flush,
  output logic                 hz_o_md_start,
  output logic                 hz_o_md_busy,
  output logic [1:0]           hz_o_state,
  output logic [CNT_WIDTH-1:0] hz_o_stall_cnt
);

  localparam int TMAX = (MD_LATENCY > FLUSH_CYCLES) ? MD_LATENCY : FLUSH_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] MD_RELOAD = TW'(MD_LATENCY - 1);
  localparam logic [TW-1:0] FL_RELOAD = TW'(FLUSH_CYCLES - 1);
  localparam logic [TW-1:0] TMR_ONE   = TW'(1);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_MD_BUSY = 2'd1,
    ST_FLUSH   = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [TW-1:0]        tmr_q, tmr_d;
  logic                 md_done_q, md_done_d;
  logic [CNT_WIDTH-1:0] stall_cnt_q;

  logic lu;
  logic stall_c, bubble_c, flush_c, md_start_c, md_busy_c;

  // A load whose destination feeds the decode-stage instruction; r0 never hazards.
  assign lu = hz_i_es_memread & hz_i_es_regwrite & (hz_i_es_addr_rd != '0) & hz_i_ds_valid &
              ((hz_i_ds_addr_rs1 == hz_i_es_addr_rd) |
               (hz_i_ds_use_rs2 & (hz_i_ds_addr_rs2 == hz_i_es_addr_rd)));

  // Next-state and hazard-output decode; branch beats load-use beats mult/div.
  always_comb begin
    state_d    = state_q;
    tmr_d      = tmr_q;
    md_done_d  = md_done_q;
    stall_c    = 1'b0;
    bubble_c   = 1'b0;
    flush_c    = 1'b0;
    md_start_c = 1'b0;
    md_busy_c  = 1'b0;
    case (state_q)
      ST_RUN: begin
        // md_done only needs to mask the single cycle in which the finished op leaves decode
        md_done_d = 1'b0;
        if (hz_i_es_branch_taken) begin
          flush_c = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_d = ST_FLUSH;
            tmr_d   = FL_RELOAD;
          end
        end else if (lu) begin
          stall_c  = 1'b1;
          bubble_c = 1'b1;
        end else if (hz_i_ds_valid && hz_i_ds_md && !md_done_q) begin
          md_start_c = 1'b1;
          stall_c    = 1'b1;
          bubble_c   = 1'b1;
          state_d    = ST_MD_BUSY;
          tmr_d      = MD_RELOAD;
        end
      end
      ST_MD_BUSY: begin
        stall_c   = 1'b1;
        bubble_c  = 1'b1;
        md_busy_c = 1'b1;
        tmr_d     = tmr_q - TMR_ONE;
        if (tmr_q == TMR_ONE) begin
          state_d   = ST_RUN;
          md_done_d = 1'b1;
        end
      end
      ST_FLUSH: begin
        flush_c = 1'b1;
        if (hz_i_es_branch_taken) begin
          tmr_d = FL_RELOAD;
        end else begin
          tmr_d = tmr_q - TMR_ONE;
          if (tmr_q == TMR_ONE) state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_RUN;
        tmr_d   = '0;
      end
    endcase
  end

  // Outputs are forced low for the whole time reset is held, even mid-sequence.
  assign hz_o_stall     = stall_c    & i_rst;
  assign hz_o_bubble    = bubble_c   & i_rst;
  assign hz_o_flush     = flush_c    & i_rst;
  assign hz_o_md_start  = md_start_c & i_rst;
  assign hz_o_md_busy   = md_busy_c  & i_rst;
  assign hz_o_state     = state_q;
  assign hz_o_stall_cnt = stall_cnt_q;

  // FSM state, cycle timer and mult/div completion flag.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q   <= ST_RUN;
      tmr_q     <= '0;
      md_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      md_done_q <= md_done_d;
    end
  end

  // Saturating stall-cycle counter; clear wins over a coincident stall.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      stall_cnt_q <= '0;
    end else if (hz_i_cnt_clr) begin
      stall_cnt_q <= '0;
    end else if (hz_o_stall && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller. u0 uses FLUSH_CYCLES=3, CNT_WIDTH=4;
// u1 uses the defaults (FLUSH_CYCLES=1, CNT_WIDTH=16) on the same stimulus.
module tb_hazard_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       ds_valid, use_rs2, ds_md, memread, regwrite, br, cnt_clr;
  logic [4:0] rs1, rs2, rd;

  logic        o0_stall, o0_bubble, o0_flush, o0_start, o0_busy;
  logic [1:0]  o0_state;
  logic [3:0]  o0_cnt;
  logic        o1_stall, o1_bubble, o1_flush, o1_start, o1_busy;
  logic [1:0]  o1_state;
  logic [15:0] o1_cnt;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  hazard_controller #(.MD_LATENCY(8), .FLUSH_CYCLES(3), .CNT_WIDTH(4), .AWIDTH(5)) u0 (
    .i_clk(clk), .i_rst(rst),
    .hz_i_ds_valid(ds_valid), .hz_i_ds_addr_rs1(rs1), .hz_i_ds_addr_rs2(rs2),
    .hz_i_ds_use_rs2(use_rs2), .hz_i_ds_md(ds_md), .hz_i_es_memread(memread),
    .hz_i_es_regwrite(regwrite), .hz_i_es_addr_rd(rd), .hz_i_es_branch_taken(br),
    .hz_i_cnt_clr(cnt_clr),
    .hz_o_stall(o0_stall), .hz_o_bubble(o0_bubble), .hz_o_flush(o0_flush),
    .hz_o_md_start(o0_start), .hz_o_md_busy(o0_busy), .hz_o_state(o0_state),
    .hz_o_stall_cnt(o0_cnt)
  );

  hazard_controller #(.MD_LATENCY(8), .FLUSH_CYCLES(1), .CNT_WIDTH(16), .AWIDTH(5)) u1 (
    .i_clk(clk), .i_rst(rst),
    .hz_i_ds_valid(ds_valid), .hz_i_ds_addr_rs1(rs1), .hz_i_ds_addr_rs2(rs2),
    .hz_i_ds_use_rs2(use_rs2), .hz_i_ds_md(ds_md), .hz_i_es_memread(memread),
    .hz_i_es_regwrite(regwrite), .hz_i_es_addr_rd(rd), .hz_i_es_branch_taken(br),
    .hz_i_cnt_clr(cnt_clr),
    .hz_o_stall(o1_stall), .hz_o_bubble(o1_bubble), .hz_o_flush(o1_flush),
    .hz_o_md_start(o1_start), .hz_o_md_busy(o1_busy), .hz_o_state(o1_state),
    .hz_o_stall_cnt(o1_cnt)
  );

  // EX is held during mult/div, so a taken branch there is a stimulus error.
  always @(posedge clk) begin
    if (rst === 1'b1 && o0_state == 2'd1 && br === 1'b1) begin
      miscompares++;
      $display("FAIL branch_in_md_busy: branch_taken got 1 required 0");
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ds_valid = 1'b0; use_rs2 = 1'b0; ds_md = 1'b0; memread = 1'b0;
    regwrite = 1'b0; br = 1'b0; cnt_clr = 1'b0;
    rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0;
  endtask

  task automatic set_lu();
    memread = 1'b1; regwrite = 1'b1; rd = 5'd5; rs1 = 5'd5; ds_valid = 1'b1;
  endtask

  task automatic clear_counter();
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    set_lu();
    ds_md = 1'b1;
    #2;
    vectors++;
    if ({o0_stall, o0_bubble, o0_flush, o0_start, o0_busy, o0_state} !== 7'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b required 0",
               {o0_stall, o0_bubble, o0_flush, o0_start, o0_busy, o0_state});
    end
    vectors++;
    if (o0_cnt !== 4'd0 || o1_cnt !== 16'd0) begin
      miscompares++;
      $display("FAIL reset_cnt: got %0d/%0d required 0/0", o0_cnt, o1_cnt);
    end
    clear_inputs();
    @(negedge clk);
    rst = 1'b1;
    tick();
  endtask

  task automatic test_load_use();
    clear_counter();
    set_lu();
    @(negedge clk);
    vectors++;
    if ({o0_stall, o0_bubble, o0_flush, o0_start} !== 4'b1100) begin
      miscompares++;
      $display("FAIL lu_rs1: stall,bubble,flush,start got %b required 1100",
               {o0_stall, o0_bubble, o0_flush, o0_start});
    end
    tick();
    clear_inputs();
    @(negedge clk);
    vectors++;
    if (o0_stall !== 1'b0 || o0_cnt !== 4'd1 || o1_cnt !== 16'd1) begin
      miscompares++;
      $display("FAIL lu_after: stall=%b cnt=%0d/%0d required 0 1/1", o0_stall, o0_cnt, o1_cnt);
    end
    memread = 1'b1; regwrite = 1'b1; rd = 5'd7; rs1 = 5'd3; rs2 = 5'd7;
    use_rs2 = 1'b1; ds_valid = 1'b1;
    #1;
    vectors++;
    if (o0_stall !== 1'b1 || o0_bubble !== 1'b1) begin
      miscompares++;
      $display("FAIL lu_rs2: stall=%b bubble=%b required 1 1", o0_stall, o0_bubble);
    end
    memread = 1'b0;
    #1;
    vectors++;
    if (o0_stall !== 1'b0) begin
      miscompares++;
      $display("FAIL lu_not_load: stall got %b required 0", o0_stall);
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_no_hazard();
    @(negedge clk);
    memread = 1'b1; regwrite = 1'b1; rd = 5'd0; rs1 = 5'd0; ds_valid = 1'b1;
    #1;
    vectors++;
    if (o0_stall !== 1'b0 || o0_bubble !== 1'b0) begin
      miscompares++;
      $display("FAIL no_lu_r0: stall=%b bubble=%b required 0 0", o0_stall, o0_bubble);
    end
    rd = 5'd10; rs1 = 5'd3; rs2 = 5'd10; use_rs2 = 1'b0;
    #1;
    vectors++;
    if (o0_stall !== 1'b0 || o0_bubble !== 1'b0) begin
      miscompares++;
      $display("FAIL no_lu_unused_rs2: stall=%b bubble=%b required 0 0", o0_stall, o0_bubble);
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_mult_div();
    logic [6:0] exp0;
    clear_counter();
    ds_valid = 1'b1; ds_md = 1'b1; rs1 = 5'd1; rs2 = 5'd2;
    for (int c = 0; c <= 8; c++) begin
      @(negedge clk);
      // {stall, bubble, flush, start, busy, state}
      exp0 = {(c < 8) ? 1'b1 : 1'b0, (c < 8) ? 1'b1 : 1'b0, 1'b0,
              (c == 0) ? 1'b1 : 1'b0, (c >= 1 && c < 8) ? 1'b1 : 1'b0,
              (c >= 1 && c < 8) ? 2'd1 : 2'd0};
      vectors++;
      if ({o0_stall, o0_bubble, o0_flush, o0_start, o0_busy, o0_state} !== exp0) begin
        miscompares++;
        $display("FAIL md_cycle%0d: got %b required %b", c,
                 {o0_stall, o0_bubble, o0_flush, o0_start, o0_busy, o0_state}, exp0);
      end
      vectors++;
      if ({o1_stall, o1_bubble, o1_flush, o1_start, o1_busy, o1_state} !== exp0) begin
        miscompares++;
        $display("FAIL md_u1_cycle%0d: got %b required %b", c,
                 {o1_stall, o1_bubble, o1_flush, o1_start, o1_busy, o1_state}, exp0);
      end
      tick();
    end
    clear_inputs();
    @(negedge clk);
    vectors++;
    if (o0_cnt !== 4'd8 || o1_cnt !== 16'd8 || o0_start !== 1'b0) begin
      miscompares++;
      $display("FAIL md_stall_cnt: cnt=%0d/%0d start=%b required 8/8 0", o0_cnt, o1_cnt, o0_start);
    end
    tick();
  endtask

  task automatic test_priority_flush();
    logic [5:0] br_seq, fl_seq;
    logic [1:0] st_seq [6];
    set_lu();
    ds_md = 1'b1; br = 1'b1;
    @(negedge clk);
    vectors++;
    if ({o0_flush, o0_stall, o0_bubble, o0_start} !== 4'b1000) begin
      miscompares++;
      $display("FAIL prio_u0: flush,stall,bubble,start got %b required 1000",
               {o0_flush, o0_stall, o0_bubble, o0_start});
    end
    vectors++;
    if ({o1_flush, o1_stall, o1_bubble, o1_start} !== 4'b1000) begin
      miscompares++;
      $display("FAIL prio_u1: flush,stall,bubble,start got %b required 1000",
               {o1_flush, o1_stall, o1_bubble, o1_start});
    end
    tick();
    clear_inputs();
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      vectors++;
      if (o0_flush !== ((c < 3) ? 1'b1 : 1'b0) || o0_state !== ((c < 3) ? 2'd2 : 2'd0)) begin
        miscompares++;
        $display("FAIL flush3_cycle%0d: flush=%b state=%0d required %b %0d", c, o0_flush,
                 o0_state, (c < 3) ? 1'b1 : 1'b0, (c < 3) ? 2 : 0);
      end
      vectors++;
      if (o1_flush !== 1'b0 || o1_state !== 2'd0) begin
        miscompares++;
        $display("FAIL flush1_cycle%0d: flush=%b state=%0d required 0 0", c, o1_flush, o1_state);
      end
      tick();
    end
    // second taken branch inside FLUSH restarts the flush window
    br_seq = 6'b000101;
    fl_seq = 6'b011111;
    st_seq = '{2'd0, 2'd2, 2'd2, 2'd2, 2'd2, 2'd0};
    for (int c = 0; c < 6; c++) begin
      br = br_seq[c];
      @(negedge clk);
      vectors++;
      if (o0_flush !== fl_seq[c] || o0_state !== st_seq[c]) begin
        miscompares++;
        $display("FAIL flush_reload_cycle%0d: flush=%b state=%0d required %b %0d", c, o0_flush,
                 o0_state, fl_seq[c], st_seq[c]);
      end
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid_md();
    ds_valid = 1'b1; ds_md = 1'b1; rs1 = 5'd1; rs2 = 5'd2;
    tick();
    tick();
    tick();
    vectors++;
    if (o0_state !== 2'd1 || o0_busy !== 1'b1) begin
      miscompares++;
      $display("FAIL md_before_reset: state=%0d busy=%b required 1 1", o0_state, o0_busy);
    end
    rst = 1'b0;
    #1;
    vectors++;
    if ({o0_stall, o0_bubble, o0_flush, o0_start, o0_busy, o0_state} !== 7'd0 ||
        o0_cnt !== 4'd0) begin
      miscompares++;
      $display("FAIL reset_mid_md: outputs %b cnt=%0d required 0 0",
               {o0_stall, o0_bubble, o0_flush, o0_start, o0_busy, o0_state}, o0_cnt);
    end
    clear_inputs();
    @(negedge clk);
    rst = 1'b1;
    tick();
    @(negedge clk);
    vectors++;
    if ({o0_stall, o0_bubble, o0_busy, o0_state} !== 5'd0 || o0_cnt !== 4'd0) begin
      miscompares++;
      $display("FAIL after_reset_release: stall,bubble,busy,state %b cnt=%0d required 0 0",
               {o0_stall, o0_bubble, o0_busy, o0_state}, o0_cnt);
    end
    tick();
  endtask

  task automatic test_saturation();
    clear_counter();
    set_lu();
    for (int i = 0; i < 15; i++) tick();
    vectors++;
    if (o0_cnt !== 4'd15) begin
      miscompares++;
      $display("FAIL sat_reach: cnt got %0d required 15", o0_cnt);
    end
    for (int i = 0; i < 5; i++) tick();
    vectors++;
    if (o0_cnt !== 4'd15 || o1_cnt !== 16'd20 || o0_stall !== 1'b1) begin
      miscompares++;
      $display("FAIL sat_hold: cnt=%0d/%0d stall=%b required 15/20 1", o0_cnt, o1_cnt, o0_stall);
    end
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    @(negedge clk);
    vectors++;
    if (o0_cnt !== 4'd0 || o1_cnt !== 16'd0) begin
      miscompares++;
      $display("FAIL clr_with_stall: cnt got %0d/%0d required 0/0", o0_cnt, o1_cnt);
    end
    tick();
    vectors++;
    if (o0_cnt !== 4'd1) begin
      miscompares++;
      $display("FAIL count_after_clr: cnt got %0d required 1", o0_cnt);
    end
    clear_inputs();
    tick();
  endtask

  initial begin
    clear_inputs();
    rst = 1'b0;
    test_reset();
    test_load_use();
    test_no_hazard();
    test_mult_div();
    test_priority_flush();
    test_reset_mid_md();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
